// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and small
// decode helpers used by the IF/ID stage and its hazard detector.
package mips_pkg;

    // Opcodes the IF/ID hazard logic cares about
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // All-zero word decodes as sll $0,$0,0, i.e. a NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction field slice positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // Fields of the ID-stage instruction needed for hazard checks
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
    } idFields_t;

    // Pull op/rs/rt out of a 32-bit instruction word
    function automatic idFields_t decodeFields(input logic [31:0] instr);
        idFields_t f;
        f.op = instr[OP_MSB:OP_LSB];
        f.rs = instr[RS_MSB:RS_LSB];
        f.rt = instr[RT_MSB:RT_LSB];
        return f;
    endfunction

    // rt is a read operand only for R-type, branches and stores
    function automatic logic opUsesRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // Branches resolve in ID, so they need their operands one stage early
    function automatic logic opIsBranch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/if_id_hazard_stage_hazard_detect.sv
// Combinational hazard detector for the instruction sitting in ID.
// Compares the ID source registers against the destinations of the
// instructions in EX and MEM and raises stall when ID must wait.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [5:0]            op,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  idValid,
    input  logic                  exMemRead,
    input  logic                  exRegWrite,
    input  logic [REG_ADDR_W-1:0] exWrAddr,
    input  logic                  memMemRead,
    input  logic [REG_ADDR_W-1:0] memWrAddr,
    output logic                  stall,
    output logic [2:0]            hazardVec
);

    logic usesRt;
    logic isBr;
    logic exSrc;
    logic memSrc;
    logic loadUse;
    logic brAfterAlu;
    logic brAfterLoad;

    // Register 0 is hard-wired to zero, so a write to it never hazards
    function automatic logic srcMatch(input logic [REG_ADDR_W-1:0] a,
                                      input logic [REG_ADDR_W-1:0] s,
                                      input logic [REG_ADDR_W-1:0] t,
                                      input logic                  rtUsed);
        return (a != '0) && ((a == s) || (rtUsed && (a == t)));
    endfunction

    // Evaluate the three hazard sources for the ID instruction
    always_comb begin
        usesRt      = opUsesRt(op);
        isBr        = opIsBranch(op);
        exSrc       = srcMatch(exWrAddr, rs, rt, usesRt);
        memSrc      = srcMatch(memWrAddr, rs, rt, usesRt);
        // Load in EX: its data only appears after MEM
        loadUse     = exMemRead && exSrc;
        // ALU result in EX is not yet forwardable to the ID comparator
        brAfterAlu  = isBr && exRegWrite && exSrc;
        // Load in MEM: branch in ID still cannot see the loaded value
        brAfterLoad = isBr && memMemRead && memSrc;
        hazardVec   = {brAfterLoad, brAfterAlu, loadUse};
        stall       = idValid && (loadUse || brAfterAlu || brAfterLoad);
    end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with in-stage hazard detection.
// Holds the fetched instruction and PC+4, freezes PC and IF/ID while the
// ID instruction waits on an operand, squashes IF/ID on a taken
// branch/jump, and counts stall cycles and redirect flushes.
//
// Flow control: fetch offers an instruction with if_valid; it is accepted
// on a rising edge whenever pc_write=1. With pc_write=0 fetch must hold
// both its PC and the offered instruction unchanged.
module if_id_hazard_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     if_instr,
    input  logic [DATA_W-1:0]     if_pc_plus4,
    input  logic                  if_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr,
    input  logic                  redirect,
    output logic [DATA_W-1:0]     id_instr,
    output logic [DATA_W-1:0]     id_pc_plus4,
    output logic                  id_valid,
    output logic                  pc_write,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [5:0]            idOp;
    logic [REG_ADDR_W-1:0] idRs;
    logic [REG_ADDR_W-1:0] idRt;
    logic                  stall;
    logic [2:0]            hazardVec;
    logic                  flush;
    logic [DATA_W-1:0]     nextInstr;
    logic                  nextValid;

    // Slice the decode fields straight out of the registered instruction
    assign idOp = id_instr[OP_MSB:OP_LSB];
    assign idRs = id_instr[RS_MSB:RS_LSB];
    assign idRt = id_instr[RT_MSB:RT_LSB];

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .op         (idOp),
        .rs         (idRs),
        .rt         (idRt),
        .idValid    (id_valid),
        .exMemRead  (ex_mem_read),
        .exRegWrite (ex_reg_write),
        .exWrAddr   (ex_wr_addr),
        .memMemRead (mem_mem_read),
        .memWrAddr  (mem_wr_addr),
        .stall      (stall),
        .hazardVec  (hazardVec)
    );

    // PC enable, bubble injection and flush decision; stall outranks
    // redirect because a stalled branch compared stale operands
    always_comb begin
        pc_write = 1'b1;
        bubble   = 1'b0;
        flush    = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
            bubble   = 1'b1;
        end else if (stall) begin
            pc_write = 1'b0;
            bubble   = 1'b1;
        end else if (redirect) begin
            flush    = 1'b1;
        end
    end

    // Next IF/ID contents when the register is allowed to advance
    always_comb begin
        nextInstr = NOP_INSTR[DATA_W-1:0];
        nextValid = 1'b0;
        if (!flush && if_valid) begin
            nextInstr = if_instr;
            nextValid = 1'b1;
        end
    end

    // IF/ID register: reset, hold on stall, otherwise advance
    always_ff @(posedge clk) begin
        if (reset) begin
            id_instr    <= NOP_INSTR[DATA_W-1:0];
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
        end else if (!stall) begin
            id_instr    <= nextInstr;
            id_pc_plus4 <= if_pc_plus4;
            id_valid    <= nextValid;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Which hazard caused a stall is visible on u_hazard.hazardVec
    logic unusedHazard;
    assign unusedHazard = ^hazardVec;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed testbench for if_id_hazard_stage.
module tb_if_id_hazard_stage;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 16;

    // Hand-assembled instructions
    localparam logic [31:0] ADD_3_2_4 = 32'h0044_1820; // add $3,$2,$4
    localparam logic [31:0] ADD_3_0_0 = 32'h0000_1820; // add $3,$0,$0
    localparam logic [31:0] BEQ_5_0   = 32'h10A0_0003; // beq $5,$0,3
    localparam logic [31:0] BNE_6_7   = 32'h14C7_0004; // bne $6,$7,4
    localparam logic [31:0] OTHER     = 32'h0000_0020; // add $0,$0,$0

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] ifInstr;
    logic [DATA_W-1:0] ifPcPlus4;
    logic              ifValid;
    logic              exMemRead;
    logic              exRegWrite;
    logic [RA_W-1:0]   exWrAddr;
    logic              memMemRead;
    logic [RA_W-1:0]   memWrAddr;
    logic              redirect;
    logic [DATA_W-1:0] idInstr;
    logic [DATA_W-1:0] idPcPlus4;
    logic              idValid;
    logic              pcWrite;
    logic              bubble;
    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  flushCnt;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    if_id_hazard_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (RA_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_instr     (ifInstr),
        .if_pc_plus4  (ifPcPlus4),
        .if_valid     (ifValid),
        .ex_mem_read  (exMemRead),
        .ex_reg_write (exRegWrite),
        .ex_wr_addr   (exWrAddr),
        .mem_mem_read (memMemRead),
        .mem_wr_addr  (memWrAddr),
        .redirect     (redirect),
        .id_instr     (idInstr),
        .id_pc_plus4  (idPcPlus4),
        .id_valid     (idValid),
        .pc_write     (pcWrite),
        .bubble       (bubble),
        .stall_cnt    (stallCnt),
        .flush_cnt    (flushCnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearHazards();
        exMemRead  = 1'b0;
        exRegWrite = 1'b0;
        exWrAddr   = '0;
        memMemRead = 1'b0;
        memWrAddr  = '0;
        redirect   = 1'b0;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        ifInstr   = '0;
        ifPcPlus4 = '0;
        ifValid   = 1'b0;
        clearHazards();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Load one instruction into ID with no hazards pending
    task automatic loadId(input logic [31:0] instr, input logic [31:0] pc);
        clearHazards();
        ifInstr   = instr;
        ifPcPlus4 = pc;
        ifValid   = 1'b1;
        tick();
        ifInstr   = OTHER;
        ifPcPlus4 = pc + 32'd4;
    endtask

    initial begin
        // Reset state, with outputs checked while reset is held
        reset = 1'b1;
        ifInstr = '0; ifPcPlus4 = '0; ifValid = 1'b0;
        clearHazards();
        tick();
        checkEq("rst_pc_write", 32'(pcWrite), 32'd0);
        checkEq("rst_bubble", 32'(bubble), 32'd1);
        tick();
        checkEq("rst_id_instr", idInstr, 32'h0);
        checkEq("rst_id_pc", idPcPlus4, 32'h0);
        checkEq("rst_id_valid", 32'(idValid), 32'd0);
        checkEq("rst_stall_cnt", 32'(stallCnt), 32'd0);
        checkEq("rst_flush_cnt", 32'(flushCnt), 32'd0);
        reset = 1'b0;

        // Normal flow through the expected queue, including an invalid fetch
        begin
            logic [31:0] instrs [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
            logic        valids [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 4; i++) begin
                ifInstr   = instrs[i];
                ifPcPlus4 = 32'h100 + 32'(4 * i);
                ifValid   = valids[i];
                exp_q.push_back(valids[i] ? instrs[i] : 32'h0);
                #1;
                checkEq("flow_pc_write", 32'(pcWrite), 32'd1);
                tick();
                checkEq("flow_id_instr", idInstr, exp_q.pop_front());
                checkEq("flow_id_valid", 32'(idValid), 32'(valids[i]));
                checkEq("flow_id_pc", idPcPlus4, 32'h100 + 32'(4 * i));
            end
        end

        // 1: lw $2 in EX, add $3,$2,$4 in ID -> one stall
        doReset();
        loadId(ADD_3_2_4, 32'h204);
        exMemRead = 1'b1; exWrAddr = 5'd2;
        #1;
        checkEq("t1_pc_write", 32'(pcWrite), 32'd0);
        checkEq("t1_bubble", 32'(bubble), 32'd1);
        tick();
        checkEq("t1_held", idInstr, ADD_3_2_4);
        checkEq("t1_held_pc", idPcPlus4, 32'h204);
        checkEq("t1_stall_cnt", 32'(stallCnt), 32'd1);
        clearHazards();
        memMemRead = 1'b1; memWrAddr = 5'd2;
        #1;
        checkEq("t1_release", 32'(pcWrite), 32'd1);
        checkEq("t1_no_bubble", 32'(bubble), 32'd0);
        tick();
        checkEq("t1_advance", idInstr, OTHER);
        checkEq("t1_stall_cnt2", 32'(stallCnt), 32'd1);

        // 2: add $5 in EX, beq $5,$0 in ID; redirect ignored during stall
        doReset();
        loadId(BEQ_5_0, 32'h300);
        exRegWrite = 1'b1; exWrAddr = 5'd5; redirect = 1'b1;
        #1;
        checkEq("t2_pc_write", 32'(pcWrite), 32'd0);
        tick();
        checkEq("t2_held", idInstr, BEQ_5_0);
        checkEq("t2_flush_cnt0", 32'(flushCnt), 32'd0);
        checkEq("t2_stall_cnt", 32'(stallCnt), 32'd1);
        exRegWrite = 1'b0; exWrAddr = 5'd0;
        #1;
        checkEq("t2_pc_write2", 32'(pcWrite), 32'd1);
        tick();
        checkEq("t2_flushed", idInstr, 32'h0);
        checkEq("t2_flushed_valid", 32'(idValid), 32'd0);
        checkEq("t2_flush_cnt1", 32'(flushCnt), 32'd1);

        // 3: lw $6 then bne $6,$7 -> two stalls (load-use, then load in MEM)
        doReset();
        loadId(BNE_6_7, 32'h400);
        exMemRead = 1'b1; exWrAddr = 5'd6;
        #1;
        checkEq("t3_stall_h1", 32'(pcWrite), 32'd0);
        tick();
        clearHazards();
        memMemRead = 1'b1; memWrAddr = 5'd6;
        #1;
        checkEq("t3_stall_h3", 32'(pcWrite), 32'd0);
        tick();
        checkEq("t3_held", idInstr, BNE_6_7);
        memMemRead = 1'b0; memWrAddr = 5'd0;
        #1;
        checkEq("t3_release", 32'(pcWrite), 32'd1);
        tick();
        checkEq("t3_stall_cnt", 32'(stallCnt), 32'd2);
        checkEq("t3_advance", idInstr, OTHER);

        // 4: load to $0 never hazards
        doReset();
        loadId(ADD_3_0_0, 32'h500);
        exMemRead = 1'b1; exWrAddr = 5'd0;
        #1;
        checkEq("t4_pc_write", 32'(pcWrite), 32'd1);
        checkEq("t4_bubble", 32'(bubble), 32'd0);
        tick();
        checkEq("t4_stall_cnt", 32'(stallCnt), 32'd0);

        // 5: redirect without hazard squashes IF/ID
        doReset();
        loadId(ADD_3_2_4, 32'h600);
        redirect = 1'b1;
        #1;
        checkEq("t5_pc_write", 32'(pcWrite), 32'd1);
        tick();
        redirect = 1'b0;
        checkEq("t5_id_instr", idInstr, 32'h0);
        checkEq("t5_id_valid", 32'(idValid), 32'd0);
        checkEq("t5_flush_cnt", 32'(flushCnt), 32'd1);

        // 6: reset asserted mid-stall
        doReset();
        loadId(ADD_3_2_4, 32'h700);
        exMemRead = 1'b1; exWrAddr = 5'd2;
        tick();
        checkEq("t6_stalled_cnt", 32'(stallCnt), 32'd1);
        reset = 1'b1;
        #1;
        checkEq("t6_rst_pc_write", 32'(pcWrite), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkEq("t6_id_valid", 32'(idValid), 32'd0);
        checkEq("t6_stall_cnt", 32'(stallCnt), 32'd0);
        checkEq("t6_no_stall", 32'(pcWrite), 32'd1);

        // 7: stall counter saturates at all-ones
        doReset();
        loadId(ADD_3_2_4, 32'h800);
        exMemRead = 1'b1; exWrAddr = 5'd2;
        repeat (65534) tick();
        checkEq("t7_cnt_fffe", 32'(stallCnt), 32'h0000_FFFE);
        repeat (3) tick();
        checkEq("t7_cnt_sat", 32'(stallCnt), 32'h0000_FFFF);
        checkEq("t7_held", idInstr, ADD_3_2_4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
